camera_capture: RTL and testbench
=================================

# camera_capture

Byte-to-pixel assembler for the OV7670-style camera port, sitting directly upstream of the RGB565-to-grayscale stage. It runs on the camera pixel clock and tracks VSYNC/HREF framing. Each pair of 8-bit bus bytes is packed into one 16-bit RGB565 word, presented as `pixel_data_out` with a one-cycle `pixel_valid` strobe. `frame_done` is held high whenever no frame is being captured.

## Interface
- `H_ACTIVE`, 640, accepted pixels per line; pixels beyond this in a line are discarded.
- `V_ACTIVE`, 480, accepted lines per frame; lines beyond this are discarded.
- `clk_in`  input  1  camera PCLK. The only clock; all logic is on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `vsync`  input  1  camera frame sync; high means vertical blank.
- `href`  input  1  camera line-valid; high while bytes are on `p_data`.
- `p_data`  input  8  camera byte bus; high byte first (R[4:0],G[5:3]), then low byte (G[2:0],B[4:0]).
- `pixel_data_out`  output  16  assembled RGB565 pixel; holds its value between strobes.
- `pixel_valid`  output  1  one-cycle strobe marking a new `pixel_data_out`.
- `frame_done`  output  1  level; 1 outside an active frame.
- `frame_error`  output  1  sticky error for the current or last frame.
- `pixel_x`, `pixel_y`  output  $clog2(H_ACTIVE), $clog2(V_ACTIVE)  coordinates of the current pixel; present only with `CAM_COORD_EN`.

## Operation
- **States:**
  - `IDLE`: entered from reset. Moves to `VBLANK` when `vsync`=1.
  - `VBLANK`: moves to `ACTIVE` when `vsync`=0.
  - `ACTIVE`: moves to `VBLANK` when `vsync`=1.
  - Requiring a full VSYNC pulse after reset means a partial frame is never captured.
- `frame_done` = 1 in `IDLE` and `VBLANK`, 0 in `ACTIVE`. It is registered from the state.
- **Byte assembly (only in `ACTIVE` with `href`=1):**
  - On phase 0, latch `p_data` as the high byte and toggle the phase.
  - On phase 1, write `{high, p_data}` to `pixel_data_out` and pulse `pixel_valid`, unless x ≥ `H_ACTIVE` or y ≥ `V_ACTIVE`. Then increment x and toggle the phase.
  - x saturates at `H_ACTIVE`.
- **Line end (`href` 1→0, detected using a registered `href`):**
  - Phase resets to 0 and x resets to 0.
  - y increments if at least one byte was seen in the line; y saturates at `V_ACTIVE`.
- **`frame_error`:**
  - Cleared on the `VBLANK`→`ACTIVE` transition.
  - Set by any of:
    - odd byte count at line end (the pending high byte is dropped);
    - x overflow (a byte pair arriving with x = `H_ACTIVE`);
    - `vsync` rising while `href`=1 or while phase = 1.
  - Once set, it holds until the next frame start.
- **Simultaneous events:**
  - `vsync`=1 together with `href`=1 in `ACTIVE`: vsync wins. No pixel is emitted, the state moves to `VBLANK`, and the pending byte is discarded.
- **Frame start:** x and y are zeroed on entry to `ACTIVE`.

## Timing
- **Reset values:**
  - `pixel_data_out` = 0, `pixel_valid` = 0, `frame_done` = 1, `frame_error` = 0.
  - `pixel_x` = `pixel_y` = 0 (with `CAM_COORD_EN`).
  - Internal: state = `IDLE`, phase = 0.
- **Reset mid-frame:** outputs return to reset values immediately. Capture resumes only after a complete VSYNC high→low sequence.
- **Latency:** the low byte is sampled at edge N. `pixel_data_out` and `pixel_valid` update at edge N, and `pixel_valid` is high for exactly the cycle following edge N. The downstream stage samples on the falling edge inside that cycle.
- **Throughput:** at most one pixel every 2 cycles; `pixel_valid` is never high on two consecutive cycles.
- **No backpressure:** the downstream stage must consume every strobe.
- **`frame_done` timing:** rises one cycle after the edge at which `vsync`=1 is sampled in `ACTIVE`. It falls one cycle after `vsync`=0 is sampled in `VBLANK`.

## Configuration
- `CAM_COORD_EN`
  - **Defined:** `pixel_x`/`pixel_y` ports exist. They are registered together with `pixel_data_out`, carrying the x and y of that pixel (before increment), and hold between strobes.
  - **Undefined:** the ports and their registers are absent. Internal x/y counters remain, because they are needed for discard and error logic.

## Test plan
- **Reset and sync:** reset, then `href`=1 bytes 0xAB,0xCD with `vsync` never pulsed → no `pixel_valid`, `frame_done`=1.
- **Basic pixel:** `vsync` 1→0, one line of bytes 0xF8,0x1F,0x07,0xE0 → two strobes with 0xF81F then 0x07E0. `frame_done`=0 and `frame_error`=0.
- **Overflow (H_ACTIVE=4, V_ACTIVE=2):**
  - a line of 6 pixels → 4 strobes and `frame_error`=1;
  - 3 lines → the third line yields no strobes.
- **Odd byte count:** a 3-byte line 0x12,0x34,0x56 → one strobe 0x1234, `frame_error`=1, and the next line starts at phase 0.
- **VSYNC mid-line:** `vsync` rises at phase 1 → no strobe, `frame_done`=1 one cycle later, `frame_error`=1. The next frame clears `frame_error`.
- **Coordinates and reset (`CAM_COORD_EN`):**
  - `pixel_x`/`pixel_y` read (0,0),(1,0),(0,1) across two lines;
  - `rst` asserted mid-line → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/camera_capture_if.sv
// camera_capture_if: groups the camera-side byte bus and the pixel-side outputs of
// camera_capture.
//   vsync, href, p_data       : camera frame sync, line valid and byte bus
//   pixel_data_out            : assembled RGB565 pixel, holds between strobes
//   pixel_valid               : one-cycle strobe marking a new pixel
//   frame_done                : level, high outside an active frame
//   frame_error               : sticky error for the current or last frame
//   pixel_x, pixel_y          : pixel coordinates, present only with CAM_COORD_EN
// Modports: slave = capture block, master = camera / downstream side.
interface camera_capture_if #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
);
  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  logic          vsync;
  logic          href;
  logic [7:0]    p_data;
  logic [15:0]   pixel_data_out;
  logic          pixel_valid;
  logic          frame_done;
  logic          frame_error;
`ifdef CAM_COORD_EN
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
`endif

  modport slave (
    input  vsync, href, p_data,
`ifdef CAM_COORD_EN
    output pixel_x, pixel_y,
`endif
    output pixel_data_out, pixel_valid, frame_done, frame_error
  );

  modport master (
    output vsync, href, p_data,
`ifdef CAM_COORD_EN
    input  pixel_x, pixel_y,
`endif
    input  pixel_data_out, pixel_valid, frame_done, frame_error
  );
endinterface

// File: rtl/camera_capture.sv
// camera_capture: assembles pairs of camera bytes into RGB565 pixels while tracking
// VSYNC/HREF framing.
// Ports:
//   clk_in : camera pixel clock, all logic on its rising edge
//   rst    : asynchronous active-high reset
//   cam    : camera_capture_if slave modport (byte bus in, pixel strobe/status out)
// Optional feature macro: CAM_COORD_EN adds registered pixel_x/pixel_y outputs.
module camera_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input logic              clk_in,
  input logic              rst,
  camera_capture_if.slave  cam
);

  // Counters need one extra code to represent the saturated value.
  localparam int unsigned XCW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YCW = $clog2(V_ACTIVE + 1);
  localparam logic [XCW-1:0] XMax = XCW'(H_ACTIVE);
  localparam logic [YCW-1:0] YMax = YCW'(V_ACTIVE);
`ifdef CAM_COORD_EN
  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
`endif

  typedef enum logic [1:0] {StIdle, StVblank, StActive} state_e;

  state_e         state_q, state_d;
  logic           phase_q, phase_d;
  logic [7:0]     high_q, high_d;
  logic [XCW-1:0] x_q, x_d;
  logic [YCW-1:0] y_q, y_d;
  logic           seen_q, seen_d;   // at least one byte seen in the current line
  logic           href_q;
  logic [15:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           done_q;
  logic           err_q, err_d;
  logic           line_end;
`ifdef CAM_COORD_EN
  logic [XW-1:0]  px_q, px_d;
  logic [YW-1:0]  py_q, py_d;
`endif

  assign line_end = href_q && !cam.href;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    high_d  = high_q;
    x_d     = x_q;
    y_d     = y_q;
    seen_d  = seen_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = err_q;
`ifdef CAM_COORD_EN
    px_d    = px_q;
    py_d    = py_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cam.vsync) state_d = StVblank;
      end
      StVblank: begin
        if (!cam.vsync) begin
          state_d = StActive;
          err_d   = 1'b0;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          seen_d  = 1'b0;
        end
      end
      StActive: begin
        if (cam.vsync) begin
          // vsync wins over a simultaneous byte; a pending high byte is dropped
          state_d = StVblank;
          phase_d = 1'b0;
          if (cam.href || phase_q) err_d = 1'b1;
        end else if (cam.href) begin
          if (!phase_q) begin
            high_d  = cam.p_data;
            phase_d = 1'b1;
            seen_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q < XMax && y_q < YMax) begin
              data_d  = {high_q, cam.p_data};
              valid_d = 1'b1;
`ifdef CAM_COORD_EN
              px_d    = x_q[XW-1:0];
              py_d    = y_q[YW-1:0];
`endif
            end
            if (x_q == XMax) err_d = 1'b1;
            else             x_d   = x_q + 1'b1;
          end
        end else if (line_end) begin
          if (phase_q) err_d = 1'b1;   // odd byte count
          phase_d = 1'b0;
          x_d     = '0;
          seen_d  = 1'b0;
          if (seen_q && y_q < YMax) y_d = y_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
      high_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      seen_q  <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b1;
      err_q   <= 1'b0;
`ifdef CAM_COORD_EN
      px_q    <= '0;
      py_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      high_q  <= high_d;
      x_q     <= x_d;
      y_q     <= y_d;
      seen_q  <= seen_d;
      href_q  <= cam.href;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= (state_q != StActive);
      err_q   <= err_d;
`ifdef CAM_COORD_EN
      px_q    <= px_d;
      py_q    <= py_d;
`endif
    end
  end

  assign cam.pixel_data_out = data_q;
  assign cam.pixel_valid    = valid_q;
  assign cam.frame_done     = done_q;
  assign cam.frame_error    = err_q;
`ifdef CAM_COORD_EN
  assign cam.pixel_x        = px_q;
  assign cam.pixel_y        = py_q;
`endif

endmodule

// File: tb/tb_camera_capture.sv
module tb_camera_capture;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  x;
    logic        y;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];

  camera_capture_if #(.H_ACTIVE(4), .V_ACTIVE(2)) cam ();

  camera_capture #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .cam    (cam)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam.href   = 1'b1;
    cam.p_data = b;
    tick();
  endtask

  task automatic end_line();
    cam.href   = 1'b0;
    cam.p_data = 8'h00;
    repeat (3) tick();
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] x, input logic y);
    exp_t e;
    e.data = d;
    e.x    = x;
    e.y    = y;
    exp_q.push_back(e);
  endtask

  task automatic vsync_pulse();
    cam.vsync = 1'b1;
    repeat (3) tick();
    cam.vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic drain(input string name);
    repeat (3) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: compares every strobe against the queued expectation.
  task automatic monitor();
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (cam.pixel_valid) begin
          if (prev_v) chk("valid_back_to_back", 32'd1, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_strobe got=%0h exp=none", cam.pixel_data_out);
          end else begin
            e = exp_q.pop_front();
            chk("pixel_data", 32'(cam.pixel_data_out), 32'(e.data));
`ifdef CAM_COORD_EN
            chk("pixel_x", 32'(cam.pixel_x), 32'(e.x));
            chk("pixel_y", 32'(cam.pixel_y), 32'(e.y));
`endif
          end
        end
        prev_v = cam.pixel_valid;
      end
    end
  endtask

  initial begin
    cam.vsync  = 1'b0;
    cam.href   = 1'b0;
    cam.p_data = 8'h00;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(negedge clk_in);
    chk("rst_data", 32'(cam.pixel_data_out), 32'h0);
    chk("rst_valid", 32'(cam.pixel_valid), 32'h0);
    chk("rst_done", 32'(cam.frame_done), 32'h1);
    chk("rst_error", 32'(cam.frame_error), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Bytes without any vsync pulse are ignored
    send_byte(8'hAB);
    send_byte(8'hCD);
    end_line();
    chk("nosync_done", 32'(cam.frame_done), 32'h1);
    drain("nosync_empty");

    // Basic pixels
    vsync_pulse();
    push(16'hF81F, 2'd0, 1'b0);
    push(16'h07E0, 2'd1, 1'b0);
    send_byte(8'hF8);
    send_byte(8'h1F);
    send_byte(8'h07);
    send_byte(8'hE0);
    end_line();
    chk("basic_done", 32'(cam.frame_done), 32'h0);
    chk("basic_error", 32'(cam.frame_error), 32'h0);
    drain("basic_empty");

    // Horizontal and vertical overflow
    vsync_pulse();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push({8'(8'h10 + i), 8'(8'h20 + i)}, 2'(i), 1'b0);
      send_byte(8'(8'h10 + i));
      send_byte(8'(8'h20 + i));
    end
    end_line();
    chk("hovf_error", 32'(cam.frame_error), 32'h1);
    push(16'h3040, 2'd0, 1'b1);
    push(16'h3141, 2'd1, 1'b1);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 2; i++) begin
        send_byte(8'(8'h30 + i));
        send_byte(8'(8'h40 + i));
      end
      end_line();
    end
    drain("ovf_empty");

    // Odd byte count; error cleared by the new frame
    vsync_pulse();
    chk("newframe_error_clr", 32'(cam.frame_error), 32'h0);
    chk("newframe_done", 32'(cam.frame_done), 32'h0);
    push(16'h1234, 2'd0, 1'b0);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    end_line();
    chk("odd_error", 32'(cam.frame_error), 32'h1);
    push(16'hAABB, 2'd0, 1'b1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    end_line();
    drain("odd_empty");

    // vsync rising at phase 1 together with a byte
    vsync_pulse();
    send_byte(8'h11);
    cam.vsync  = 1'b1;
    cam.href   = 1'b1;
    cam.p_data = 8'h22;
    tick();
    cam.href = 1'b0;
    @(negedge clk_in);
    chk("vs_done_lag", 32'(cam.frame_done), 32'h0);
    chk("vs_error", 32'(cam.frame_error), 32'h1);
    tick();
    @(negedge clk_in);
    chk("vs_done", 32'(cam.frame_done), 32'h1);
    tick();
    vsync_pulse();
    chk("vs_error_clr", 32'(cam.frame_error), 32'h0);
    drain("vs_empty");

    // Asynchronous reset mid-line
    push(16'h5AA5, 2'd0, 1'b0);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'hC3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", 32'(cam.pixel_data_out), 32'h0);
    chk("arst_valid", 32'(cam.pixel_valid), 32'h0);
    chk("arst_done", 32'(cam.frame_done), 32'h1);
    chk("arst_error", 32'(cam.frame_error), 32'h0);
`ifdef CAM_COORD_EN
    chk("arst_x", 32'(cam.pixel_x), 32'h0);
    chk("arst_y", 32'(cam.pixel_y), 32'h0);
`endif
    cam.href = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    // Capture must not resume without a full vsync pulse
    send_byte(8'h01);
    send_byte(8'h02);
    end_line();
    chk("post_rst_done", 32'(cam.frame_done), 32'h1);
    drain("final_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
